// File: rtl/vga_scan_timer.sv
// Raster-scan timing generator for VGA: sweeps (x, y) for the pixel drawer and
// registers blank-gated colour and active-low syncs one pixel period later.
module vga_scan_timer #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [8:0] y,
  input  logic [8:0] pixel_data,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_tick
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  logic [8:0]       color;
  logic             h_wrap, v_wrap, vis, hs_n, vs_n;

  assign pix_tick = (div_cnt == DIV_LAST);
  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);
  assign vis      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_n     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_n     = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  assign x = h_cnt;
  assign y = (v_cnt < V_VIS) ? v_cnt[8:0] : 9'd0;
  assign {vga_r, vga_g, vga_b} = color;

  // Counters and the output stage advance on the same pix_tick edge, so the
  // pins always show the coordinate of the previous pixel period.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      color      <= '0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      video_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= pix_tick ? '0 : div_cnt + DIV_W'(1);
      frame_tick <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        h_cnt    <= h_wrap ? 10'd0 : h_cnt + 10'd1;
        if (h_wrap)
          v_cnt  <= v_wrap ? 10'd0 : v_cnt + 10'd1;
        color    <= vis ? pixel_data : 9'd0;
        vga_hs   <= hs_n;
        vga_vs   <= vs_n;
        video_on <= vis;
      end
    end
  end
endmodule

// File: doc/vga_scan_timer.md
# vga_scan_timer

Raster-scan timing generator and pixel output stage for the 640x480@60 Hz VGA display. Sweeps the pixel coordinate (x, y) consumed by the combinational pixel drawer, samples the 9-bit RGB333 colour it returns, and drives registered, blank-gated colour plus sync pulses to the VGA connector. It also emits a once-per-frame tick that game logic uses to advance car and obstacle positions.

## Interface
Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz clk gives a 25 MHz pixel rate); legal values are 1 or more.
- H_VISIBLE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal widths in pixels.
- V_VISIBLE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical widths in lines.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- x  out  10  current pixel column sent to the drawer.
- y  out  9  current pixel row sent to the drawer.
- pixel_data  in  9  colour {R[2:0],G[2:0],B[2:0]} returned by the drawer for (x, y).
- vga_r, vga_g, vga_b  out  3 each  registered colour.
- vga_hs, vga_vs  out  1 each  registered syncs, active low.
- video_on  out  1  registered; high when the outputs carry a visible pixel.
- pix_tick  out  1  one-clk strobe marking each pixel period.
- frame_tick  out  1  one-clk pulse at frame wrap.

## Operation
- One clock domain. Reset is synchronous and active-high.
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525 with the default parameters.
- Pixel divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div_cnt == CLK_DIV-1), as a combinational decode.
  - With CLK_DIV=1, pix_tick is high on every clk.
- Horizontal counter:
  - h_cnt (10 bits) increments on each pix_tick.
  - At H_TOTAL-1 it wraps to 0 and v_cnt advances.
- Vertical counter:
  - v_cnt (10 bits) increments when h_cnt wraps.
  - At V_TOTAL-1 it wraps to 0.
- Combinational outputs:
  - x = h_cnt.
  - y = v_cnt[8:0] when v_cnt < V_VISIBLE, else 0.
  - vis = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - hs_n is low for h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. [656,752).
  - vs_n is low for v_cnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. [490,492).
- Output register: updates only on pix_tick edges.
  - {vga_r,vga_g,vga_b} <= vis ? pixel_data : 0.
  - vga_hs <= hs_n; vga_vs <= vs_n; video_on <= vis.
  - Counters and output register share the same edge, so outputs reflect the counter values of the preceding pixel period.
- frame_tick: registered. It is high for exactly one clk after the pix_tick edge on which h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1.
- Reset values:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0.
  - RGB = 0, vga_hs = 1, vga_vs = 1.
  - video_on = 0, frame_tick = 0.
  - Hence x = 0 and y = 0 in the cycle after reset.

## Timing
- Drawer path is combinational: x/y change → pixel_data must settle within one pixel period (CLK_DIV clocks).
- Latency from a given (x, y) to its colour on the pins: exactly one pixel period.
- Sync pulses carry the same one-pixel delay as colour, so alignment is preserved.
- Line = 800 pixel periods. Frame = 420000 pixel periods (840000 clk at CLK_DIV=2).
- vga_hs: low for 96 consecutive pixel periods per line.
- vga_vs: low for 2 lines = 1600 pixel periods; it changes only at the pix_tick edge where h_cnt = 0 is registered.
- Reset asserted mid-frame: on the next clk edge, all state and outputs return to their reset values regardless of pix_tick. Scanning restarts at (0,0) on the first pix_tick after reset deasserts.
- pixel_data is ignored outside the visible area; RGB is forced to 0 during all blanking.

## Test plan
- Reset: hold reset 3 clk with pixel_data = 9'h1FF → RGB = 0, hs = vs = 1, video_on = 0, frame_tick = 0, x = 0, y = 0.
- Pixel passthrough: CLK_DIV=2, pixel_data = 9'b111_000_000 while x = 0, y = 0 → vga_r = 7, vga_g = 0, vga_b = 0, video_on = 1, beginning one pixel period (2 clk) later.
- Blanking: pixel_data = 9'h1FF constant → RGB = 0 whenever the registered column is ≥ 640 or the row is ≥ 480, and RGB = 9'h1FF otherwise.
- Sync geometry: measure over 2 frames → hs low for 96 pix periods every 800, falling after column 656 is registered; vs low for 1600 pix periods every 420000, starting at line 490.
- Frame tick: count clk between frame_tick pulses → 840000 (CLK_DIV=2) and 420000 (CLK_DIV=1); each pulse is exactly 1 clk wide.
- Mid-frame reset: assert reset at h = 300, v = 200 for 1 clk → next cycle x = 0, y = 0 with outputs at reset values; the first frame_tick arrives exactly 420000 pix periods after release.
